// File: rtl/select_control_unit_pkg.sv
// Shared constants for the select/encode control unit: step encodings,
// opcode map, ALU ADD code and the registered control bundle.
// Optional mul/div support: SELECT_CTRL_MULDIV_EN.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        T0, T1, T2, T3, T4, T5, T6, T7
    } step_t;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;

    typedef struct packed {
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       pc_out;
        logic       pc_in;
        logic       inc_pc;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       zlow_out;
        logic       zhigh_out;
        logic       hi_in;
        logic       lo_in;
        logic       c_out;
        logic       con_in;
        logic       read;
        logic       write;
        logic [4:0] alu_op;
    } ctrl_t;

    // Final step of each instruction; unknown opcodes end at T2.
    function automatic step_t last_step(logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_LDI, OP_ADDI: return T5;
            OP_LD, OP_ST:    return T7;
            OP_BR:           return T6;
`ifdef SELECT_CTRL_MULDIV_EN
            OP_MUL, OP_DIV:  return T6;
`endif
            default:         return T2;
        endcase
    endfunction

endpackage

// File: rtl/select_control_unit_if.sv
// Control-unit bus: instruction/status inputs and all control strobes.
// master = control unit side, slave = datapath side.
interface select_control_unit_if;
    logic       stop;
    logic [4:0] opcode;
    logic       con_ff;
    logic       mem_ready;
    logic       gra, grb, grc, r_in, r_out, ba_out;
    logic       pc_out, pc_in, inc_pc, mar_in;
    logic       mdr_in, mdr_out, ir_in;
    logic       y_in, z_in, zlow_out, zhigh_out;
    logic       hi_in, lo_in, c_out, con_in;
    logic       read, write;
    logic [4:0] alu_op;
    logic       run;
    logic [2:0] step;

    modport master (
        input  stop, opcode, con_ff, mem_ready,
        output gra, grb, grc, r_in, r_out, ba_out,
        output pc_out, pc_in, inc_pc, mar_in,
        output mdr_in, mdr_out, ir_in,
        output y_in, z_in, zlow_out, zhigh_out,
        output hi_in, lo_in, c_out, con_in,
        output read, write, alu_op, run, step
    );

    modport slave (
        output stop, opcode, con_ff, mem_ready,
        input  gra, grb, grc, r_in, r_out, ba_out,
        input  pc_out, pc_in, inc_pc, mar_in,
        input  mdr_in, mdr_out, ir_in,
        input  y_in, z_in, zlow_out, zhigh_out,
        input  hi_in, lo_in, c_out, con_in,
        input  read, write, alu_op, run, step
    );
endinterface

// File: rtl/select_control_unit_step_decoder.sv
// Combinational step/opcode -> control bundle decode (step_decoder).
// In: step, op, halted, con_ff. Out: ctrl. Mul/div: SELECT_CTRL_MULDIV_EN.
module step_decoder
    import cpu_ctrl_pkg::*;
(
    input  step_t      step,
    input  logic [4:0] op,
    input  logic       halted,
    input  logic       con_ff,
    output ctrl_t      ctrl
);

    logic is_alu, is_imm, is_mem, is_ld, is_st, is_br, is_md;

    assign is_ld  = (op == OP_LD);
    assign is_st  = (op == OP_ST);
    assign is_mem = is_ld | is_st;
    assign is_imm = (op == OP_LDI) | (op == OP_ADDI);
    assign is_br  = (op == OP_BR);
    assign is_alu = (op == OP_ADD) | (op == OP_SUB) |
                    (op == OP_AND) | (op == OP_OR);
`ifdef SELECT_CTRL_MULDIV_EN
    assign is_md  = (op == OP_MUL) | (op == OP_DIV);
`else
    assign is_md  = 1'b0;
`endif

    always_comb begin
        ctrl = '0;
        if (!halted) begin
            case (step)
                T0: begin
                    ctrl.pc_out = 1'b1;
                    ctrl.mar_in = 1'b1;
                    ctrl.inc_pc = 1'b1;
                    ctrl.z_in   = 1'b1;
                end
                T1: begin
                    ctrl.zlow_out = 1'b1;
                    ctrl.pc_in    = 1'b1;
                    ctrl.read     = 1'b1;
                    ctrl.mdr_in   = 1'b1;
                end
                T2: begin
                    ctrl.mdr_out = 1'b1;
                    ctrl.ir_in   = 1'b1;
                end
                T3: unique case (1'b1)
                    is_alu: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    is_imm, is_mem: begin
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    is_br: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.con_in = 1'b1;
                    end
                    is_md: begin
                        ctrl.gra   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    default: ;
                endcase
                T4: unique case (1'b1)
                    is_alu: begin
                        ctrl.grc    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = op;
                    end
                    is_imm, is_mem: begin
                        ctrl.c_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = ALU_ADD;
                    end
                    is_br: begin
                        ctrl.pc_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    is_md: begin
                        ctrl.grb    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = op;
                    end
                    default: ;
                endcase
                T5: unique case (1'b1)
                    is_alu, is_imm: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end
                    is_mem: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.mar_in   = 1'b1;
                    end
                    is_br: begin
                        ctrl.c_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = ALU_ADD;
                    end
                    is_md: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.lo_in    = 1'b1;
                    end
                    default: ;
                endcase
                T6: unique case (1'b1)
                    is_ld: begin
                        ctrl.read   = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    is_st: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    is_br: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.pc_in    = con_ff;
                    end
                    is_md: begin
                        ctrl.zhigh_out = 1'b1;
                        ctrl.hi_in     = 1'b1;
                    end
                    default: ;
                endcase
                T7: unique case (1'b1)
                    is_ld: begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    is_st: ctrl.write = 1'b1;
                    default: ;
                endcase
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/select_control_unit.sv
// Step sequencer with registered Moore control outputs.
// Ports: clock, reset, bus (master). Mul/div: SELECT_CTRL_MULDIV_EN.
module select_control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    select_control_unit_if.master bus
);

    step_t      step_q, step_d;
    logic [4:0] op_q, op_d, cur_op;
    logic       halted_q, halted_d;
    logic       idle_q, run_q, mem_wait;
    ctrl_t      ctrl_q, ctrl_d;

    // In T2 the opcode is still on the bus; later steps use the latch.
    assign cur_op = (step_q == T2) ? bus.opcode : op_q;

    assign mem_wait = !bus.mem_ready &&
        ((step_q == T1) ||
         (step_q == T6 && op_q == OP_LD) ||
         (step_q == T7 && op_q == OP_ST));

    always_comb begin
        step_d   = step_q;
        op_d     = op_q;
        halted_d = halted_q;
        // idle_q: one quiet T0 right after reset, then T0 controls.
        if (idle_q || halted_q) begin
            step_d = T0;
        end else if (!mem_wait) begin
            if (step_q == T2)
                op_d = bus.opcode;
            if (step_q == T2 && bus.opcode == OP_HALT) begin
                step_d   = T0;
                halted_d = 1'b1;
            end else if (step_q == last_step(cur_op)) begin
                step_d   = T0;
                halted_d = bus.stop;
            end else begin
                step_d = step_t'(step_q + 3'd1);
            end
        end
    end

    // Decode the next state so the registered outputs match step_q.
    step_decoder u_dec (
        .step   (step_d),
        .op     (op_d),
        .halted (halted_d),
        .con_ff (bus.con_ff),
        .ctrl   (ctrl_d)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            step_q   <= T0;
            op_q     <= '0;
            halted_q <= 1'b0;
            idle_q   <= 1'b1;
            ctrl_q   <= '0;
            run_q    <= 1'b1;
        end else begin
            step_q   <= step_d;
            op_q     <= op_d;
            halted_q <= halted_d;
            idle_q   <= 1'b0;
            ctrl_q   <= ctrl_d;
            run_q    <= ~halted_d;
        end
    end

    assign bus.gra       = ctrl_q.gra;
    assign bus.grb       = ctrl_q.grb;
    assign bus.grc       = ctrl_q.grc;
    assign bus.r_in      = ctrl_q.r_in;
    assign bus.r_out     = ctrl_q.r_out;
    assign bus.ba_out    = ctrl_q.ba_out;
    assign bus.pc_out    = ctrl_q.pc_out;
    assign bus.pc_in     = ctrl_q.pc_in;
    assign bus.inc_pc    = ctrl_q.inc_pc;
    assign bus.mar_in    = ctrl_q.mar_in;
    assign bus.mdr_in    = ctrl_q.mdr_in;
    assign bus.mdr_out   = ctrl_q.mdr_out;
    assign bus.ir_in     = ctrl_q.ir_in;
    assign bus.y_in      = ctrl_q.y_in;
    assign bus.z_in      = ctrl_q.z_in;
    assign bus.zlow_out  = ctrl_q.zlow_out;
    assign bus.zhigh_out = ctrl_q.zhigh_out;
    assign bus.hi_in     = ctrl_q.hi_in;
    assign bus.lo_in     = ctrl_q.lo_in;
    assign bus.c_out     = ctrl_q.c_out;
    assign bus.con_in    = ctrl_q.con_in;
    assign bus.read      = ctrl_q.read;
    assign bus.write     = ctrl_q.write;
    assign bus.alu_op    = ctrl_q.alu_op;
    assign bus.run       = run_q;
    assign bus.step      = step_q;

endmodule

// File: tb/tb_select_control_unit.sv
// Directed bench for select_control_unit: fetch, ALU, ld/st stalls,
// branch, nop, mul/div, stop, halt and reset-during-stall.
module tb_select_control_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    select_control_unit_if bus ();

    select_control_unit dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [27:0] all_ctrl;
    assign all_ctrl = {
        bus.gra, bus.grb, bus.grc, bus.r_in, bus.r_out, bus.ba_out,
        bus.pc_out, bus.pc_in, bus.inc_pc, bus.mar_in,
        bus.mdr_in, bus.mdr_out, bus.ir_in,
        bus.y_in, bus.z_in, bus.zlow_out, bus.zhigh_out,
        bus.hi_in, bus.lo_in, bus.c_out, bus.con_in,
        bus.read, bus.write, bus.alu_op
    };

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic adv(input logic [2:0] exp_step);
        tick();
        chk("step", {29'd0, bus.step}, {29'd0, exp_step});
    endtask

    initial begin
        bus.stop      = 1'b0;
        bus.opcode    = 5'b00000;
        bus.con_ff    = 1'b0;
        bus.mem_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_step", {29'd0, bus.step}, 0);
        chk("rst_run", {31'd0, bus.run}, 1);
        chk("rst_ctrl", {4'd0, all_ctrl}, 0);

        // First cycle after release drives T0 fetch
        rst = 1'b0;
        adv(0);
        chk("t0_pc_out", {31'd0, bus.pc_out}, 1);
        chk("t0_mar_in", {31'd0, bus.mar_in}, 1);
        chk("t0_inc_pc", {31'd0, bus.inc_pc}, 1);
        chk("t0_z_in", {31'd0, bus.z_in}, 1);

        // add
        bus.opcode = 5'b00011;
        adv(1);
        chk("t1_read", {31'd0, bus.read}, 1);
        chk("t1_pc_in", {31'd0, bus.pc_in}, 1);
        adv(2);
        chk("t2_ir_in", {31'd0, bus.ir_in}, 1);
        adv(3);
        chk("add_t3_grb", {31'd0, bus.grb}, 1);
        chk("add_t3_y_in", {31'd0, bus.y_in}, 1);
        adv(4);
        chk("add_t4_alu", {27'd0, bus.alu_op}, 3);
        chk("add_t4_grc", {31'd0, bus.grc}, 1);
        chk("add_t4_r_out", {31'd0, bus.r_out}, 1);
        adv(5);
        chk("add_t5_r_in", {31'd0, bus.r_in}, 1);
        chk("add_t5_zlow", {31'd0, bus.zlow_out}, 1);
        adv(0);
        chk("add_t0_pc_out", {31'd0, bus.pc_out}, 1);

        // ld with 3-cycle stall in T6
        bus.opcode = 5'b00000;
        adv(1);
        adv(2);
        adv(3);
        chk("ld_t3_ba_out", {31'd0, bus.ba_out}, 1);
        adv(4);
        chk("ld_t4_c_out", {31'd0, bus.c_out}, 1);
        chk("ld_t4_alu", {27'd0, bus.alu_op}, 3);
        adv(5);
        chk("ld_t5_mar_in", {31'd0, bus.mar_in}, 1);
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adv(6);
            chk("ld_t6_read", {31'd0, bus.read}, 1);
            chk("ld_t6_mdr_in", {31'd0, bus.mdr_in}, 1);
        end
        bus.mem_ready = 1'b1;
        adv(7);
        chk("ld_t7_gra", {31'd0, bus.gra}, 1);
        chk("ld_t7_r_in", {31'd0, bus.r_in}, 1);
        chk("ld_t7_read", {31'd0, bus.read}, 0);
        adv(0);

        // st with one stall in T7
        bus.opcode = 5'b00010;
        adv(1);
        adv(2);
        adv(3);
        adv(4);
        adv(5);
        adv(6);
        chk("st_t6_r_out", {31'd0, bus.r_out}, 1);
        chk("st_t6_mdr_in", {31'd0, bus.mdr_in}, 1);
        bus.mem_ready = 1'b0;
        adv(7);
        chk("st_t7_write", {31'd0, bus.write}, 1);
        adv(7);
        chk("st_t7_hold", {31'd0, bus.write}, 1);
        bus.mem_ready = 1'b1;
        adv(0);

        // br, con_ff = 0 then 1
        bus.opcode = 5'b10010;
        for (int c = 0; c < 2; c++) begin
            bus.con_ff = c[0];
            adv(1);
            adv(2);
            adv(3);
            chk("br_t3_con_in", {31'd0, bus.con_in}, 1);
            adv(4);
            adv(5);
            chk("br_t5_alu", {27'd0, bus.alu_op}, 3);
            adv(6);
            chk("br_t6_zlow", {31'd0, bus.zlow_out}, 1);
            chk("br_t6_pc_in", {31'd0, bus.pc_in}, {31'd0, c[0]});
            adv(0);
        end
        bus.con_ff = 1'b0;

        // nop
        bus.opcode = 5'b11010;
        adv(1);
        adv(2);
        adv(0);

        // mul
        bus.opcode = 5'b01111;
        adv(1);
        adv(2);
`ifdef SELECT_CTRL_MULDIV_EN
        adv(3);
        adv(4);
        chk("mul_t4_alu", {27'd0, bus.alu_op}, 15);
        adv(5);
        chk("mul_t5_lo_in", {31'd0, bus.lo_in}, 1);
        adv(6);
        chk("mul_t6_hi_in", {31'd0, bus.hi_in}, 1);
`endif
        adv(0);

        // sub with stop raised in T3
        bus.opcode = 5'b00100;
        adv(1);
        adv(2);
        adv(3);
        bus.stop = 1'b1;
        adv(4);
        chk("sub_t4_alu", {27'd0, bus.alu_op}, 4);
        adv(5);
        chk("sub_t5_run", {31'd0, bus.run}, 1);
        adv(0);
        chk("stop_run", {31'd0, bus.run}, 0);
        chk("stop_ctrl", {4'd0, all_ctrl}, 0);
        adv(0);
        chk("stop_run2", {31'd0, bus.run}, 0);
        bus.stop = 1'b0;
        rst = 1'b1;
        adv(0);
        chk("stop_rst_run", {31'd0, bus.run}, 1);
        rst = 1'b0;
        adv(0);
        chk("rel_pc_out", {31'd0, bus.pc_out}, 1);

        // halt opcode
        bus.opcode = 5'b11011;
        adv(1);
        adv(2);
        adv(0);
        chk("halt_run", {31'd0, bus.run}, 0);
        chk("halt_ctrl", {4'd0, all_ctrl}, 0);
        rst = 1'b1;
        adv(0);
        rst = 1'b0;
        adv(0);
        chk("halt_rel_run", {31'd0, bus.run}, 1);

        // reset during ld T6 stall
        bus.opcode = 5'b00000;
        adv(1);
        adv(2);
        adv(3);
        adv(4);
        adv(5);
        bus.mem_ready = 1'b0;
        adv(6);
        adv(6);
        rst = 1'b1;
        adv(0);
        chk("rst_stall_read", {31'd0, bus.read}, 0);
        chk("rst_stall_run", {31'd0, bus.run}, 1);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        adv(0);
        chk("rst_stall_fetch", {31'd0, bus.pc_out}, 1);
        adv(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/select_control_unit.md
SELECT_CONTROL_UNIT -- requirements
Module: select_control_unit

Interface
REQ-001 clock  input  1  rising-edge clock; sole clock.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 stop  input  1  halt request; sampled only at instruction boundary.
REQ-004 opcode  input  5  IR[31:27].
REQ-005 con_ff  input  1  branch-condition flag.
REQ-006 mem_ready  input  1  memory completed current read/write.
REQ-007 gra, grb, grc, r_in, r_out, ba_out  output  1 each  register select/encode controls.
REQ-008 pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in  output  1 each  fetch/memory datapath enables.
REQ-009 y_in, z_in, zlow_out, zhigh_out, hi_in, lo_in, c_out, con_in  output  1 each  ALU-path enables.
REQ-010 read, write  output  1 each  memory strobes.
REQ-011 alu_op  output  5  ALU operation code.
REQ-012 run  output  1  high unless halted.
REQ-013 step  output  3  current step T0..T7.

Function
REQ-014 All control outputs SHALL be Moore outputs decoded from registered state (step, halted flag, latched opcode); none combinational from inputs.
REQ-015 Opcode SHALL be latched at end of T2; execute steps use the latched value.
REQ-016 Fetch: T0 pc_out,mar_in,inc_pc,z_in; T1 zlow_out,pc_in,read,mdr_in; T2 mdr_out,ir_in.
REQ-017 add 00011/sub 00100/and 00101/or 00110: T3 grb,r_out,y_in; T4 grc,r_out,z_in,alu_op=opcode; T5 zlow_out,gra,r_in; then T0.
REQ-018 ldi 00001/addi 01100: T3 grb,ba_out,y_in; T4 c_out,z_in,alu_op=00011; T5 zlow_out,gra,r_in; then T0.
REQ-019 ld 00000: T3/T4 as ldi; T5 zlow_out,mar_in; T6 read,mdr_in; T7 mdr_out,gra,r_in; then T0.
REQ-020 st 00010: T3/T4 as ldi; T5 zlow_out,mar_in; T6 gra,r_out,mdr_in; T7 write; then T0.
REQ-021 br 10010: T3 gra,r_out,con_in; T4 pc_out,y_in; T5 c_out,z_in,alu_op=00011; T6 zlow_out, pc_in only if con_ff=1; then T0.
REQ-022 halt 11011: after T2 enter HALTED (run=0, all controls 0, step=0) until reset.
REQ-023 Any other opcode (incl. nop 11010) SHALL return T2->T0 with no execute steps.
REQ-024 Memory steps (T1 fetch, ld T6, st T7) SHALL hold step and all outputs while mem_ready=0; advance on first cycle mem_ready=1; minimum one cycle per step.
REQ-025 stop=1 sampled in the final step of an instruction SHALL enter HALTED instead of T0; stop in other steps ignored.
REQ-026 Non-memory steps SHALL each take exactly one cycle.

Reset
REQ-027 reset=1 SHALL force step=0 (T0), run=1, latched opcode=0, all controls 0 next cycle, overriding any stall or HALTED state, mid-instruction included.
REQ-028 The first cycle after reset deasserts SHALL drive T0 fetch controls.

Configuration
REQ-029 Macro SELECT_CTRL_MULDIV_EN: when defined, mul 01111/div 10000 SHALL run T3 gra,r_out,y_in; T4 grb,r_out,z_in,alu_op=opcode; T5 zlow_out,lo_in; T6 zhigh_out,hi_in; then T0.
REQ-030 Without SELECT_CTRL_MULDIV_EN, 01111/10000 SHALL follow REQ-023.

Structure
REQ-031 Opcode constants, ALU op ADD, and step encodings SHALL live in shared package cpu_ctrl_pkg.
REQ-032 Single sub-module step_decoder (step + opcode -> control outputs, combinational) feeding output registers; sequencing FSM in top.

Verification
REQ-033 Reset then add (00011), mem_ready=1 -> steps 0,1,2,3,4,5,0; T4 alu_op=00011, grc=1,r_out=1.
REQ-034 ld with mem_ready low 3 cycles in T6 -> step holds 6 with read=1,mdr_in=1 for 4 cycles, then T7 gra,r_in.
REQ-035 br with con_ff=0 -> T6 zlow_out=1, pc_in=0; with con_ff=1 -> pc_in=1.
REQ-036 stop=1 during T3 of sub, held -> completes T5, then run=0, step=0, outputs 0; reset -> run=1.
REQ-037 mul (01111) with macro -> T5 lo_in=1, T6 hi_in=1; without macro -> T2 then T0.
REQ-038 reset asserted at ld T6 stall -> next cycle step=0, read=0, run=1.
